// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    function automatic int div_cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit and trial-subtract the divisor.
module div_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] rem_in,
    input  logic         in_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0] w_shifted;
    logic [W:0] w_diff_lo;

    assign w_shifted = {rem_in, in_bit};
    // A set top bit means the shifted value exceeds any W-bit divisor, so the subtract always succeeds.
    assign w_diff_lo = {1'b0, w_shifted[W-1:0]} - {1'b0, divisor};
    assign q_bit     = w_shifted[W] | ~w_diff_lo[W];
    assign rem_out   = q_bit ? w_diff_lo[W-1:0] : w_shifted[W-1:0];

endmodule

// File: rtl/seq_div16.sv
// Multi-cycle signed/unsigned divider: magnitude restoring divide, then a sign fix-up cycle.
module seq_div16
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : div_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_dsr;
    logic             r_dvd_neg;
    logic             r_quo_neg;
    logic             r_dbz;
    logic             r_busy;
    logic             r_done;
    logic             r_div_by_zero;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic [WIDTH-1:0] w_rem_next;
    logic             w_q_bit;
    logic             w_dvd_neg;
    logic             w_dsr_neg;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    assign w_dvd_neg = is_signed & dividend[WIDTH-1];
    assign w_dsr_neg = is_signed & divisor[WIDTH-1];

    // r_acc starts as the dividend magnitude and fills with quotient bits as it shifts out.
    div_step #(.W(WIDTH)) u_step (
        .rem_in  (r_rem),
        .in_bit  (r_acc[WIDTH-1]),
        .divisor (r_dsr),
        .rem_out (w_rem_next),
        .q_bit   (w_q_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_rem         <= '0;
            r_acc         <= '0;
            r_dsr         <= '0;
            r_dvd_neg     <= 1'b0;
            r_quo_neg     <= 1'b0;
            r_dbz         <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc         <= cond_neg(dividend, w_dvd_neg);
                        r_dsr         <= cond_neg(divisor, w_dsr_neg);
                        r_dvd_neg     <= w_dvd_neg;
                        r_quo_neg     <= w_dvd_neg ^ w_dsr_neg;
                        r_dbz         <= (divisor == '0);
                        r_rem         <= '0;
                        r_cnt         <= '0;
                        r_busy        <= 1'b1;
                        r_div_by_zero <= 1'b0;
                        r_state       <= (divisor == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_next;
                    r_acc <= {r_acc[WIDTH-2:0], w_q_bit};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_ITER) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (r_dbz) begin
                        r_quotient    <= '1;
                        r_remainder   <= cond_neg(r_acc, r_dvd_neg);
                        r_div_by_zero <= 1'b1;
                    end else begin
                        r_quotient    <= cond_neg(r_acc, r_quo_neg);
                        r_remainder   <= cond_neg(r_rem, r_dvd_neg);
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_div16.sv
// Directed + scoreboard bench for seq_div16: expected results queued at start, checked at done.
module tb_seq_div16;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    seq_div16 #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference results from the language's own / and % (truncating, remainder follows dividend).
    function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   sa;
        int   sd;
        e.dbz = 1'b0;
        e.lat = 17;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
            e.lat = 1;
        end else if (sgn) begin
            sa  = int'($signed(a));
            sd  = int'($signed(b));
            e.q = W'(sa / sd);
            e.r = W'(sa % sd);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    task automatic run_op(input string name, input logic sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b, input exp_t e, input int inject,
                          input bit hold_check);
        exp_t got;
        int   lat;
        sb.push_back(e);
        @(negedge clk);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, "_busy_set"}, 32'(busy), 32'd1);
        lat = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc == inject) begin
                start     = 1'b1;
                is_signed = ~sgn;
                dividend  = 16'h5555;
                divisor   = 16'h0003;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat = cyc;
                break;
            end
        end
        got = sb.pop_front();
        check({name, "_latency"}, 32'(lat), 32'(got.lat));
        check({name, "_quotient"}, 32'(quotient), 32'(got.q));
        check({name, "_remainder"}, 32'(remainder), 32'(got.r));
        check({name, "_dbz"}, 32'(div_by_zero), 32'(got.dbz));
        check({name, "_busy_clr"}, 32'(busy), 32'd0);
        $display("op %s sgn=%0d %h / %h -> q=%h r=%h dbz=%0d lat=%0d",
                 name, sgn, a, b, quotient, remainder, div_by_zero, lat);
        if (hold_check) begin
            @(posedge clk);
            #1;
            check({name, "_done_pulse"}, 32'(done), 32'd0);
            check({name, "_q_hold"}, 32'(quotient), 32'(got.q));
            check({name, "_r_hold"}, 32'(remainder), 32'(got.r));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t         e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        bit           seen;

        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("u100_7", 1'b0, 16'd100, 16'd7, '{q: 16'd14, r: 16'd2, dbz: 1'b0, lat: 17}, 0, 1'b1);
        run_op("s_m7_2", 1'b1, 16'hFFF9, 16'd2, '{q: 16'hFFFD, r: 16'hFFFF, dbz: 1'b0, lat: 17}, 0, 1'b1);
        run_op("u_fff9_2", 1'b0, 16'hFFF9, 16'd2, '{q: 16'h7FFC, r: 16'h0001, dbz: 1'b0, lat: 17}, 0, 1'b1);
        run_op("dbz_1234", 1'b0, 16'h1234, 16'h0000, '{q: 16'hFFFF, r: 16'h1234, dbz: 1'b1, lat: 1}, 0, 1'b1);
        run_op("s_min_m1", 1'b1, 16'h8000, 16'hFFFF, '{q: 16'h8000, r: 16'h0000, dbz: 1'b0, lat: 17}, 0, 1'b1);
        run_op("ignore_start", 1'b0, 16'd100, 16'd7, '{q: 16'd14, r: 16'd2, dbz: 1'b0, lat: 17}, 5, 1'b1);

        // Second start issued in the cycle done is high.
        run_op("b2b_a", 1'b1, 16'hFF38, 16'd7, '{q: 16'hFFE4, r: 16'hFFFC, dbz: 1'b0, lat: 17}, 0, 1'b0);
        run_op("b2b_b", 1'b0, 16'd50000, 16'd123, '{q: 16'd406, r: 16'd62, dbz: 1'b0, lat: 17}, 0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom);
            rb = (i == 3) ? 16'h0000 : W'($urandom_range(1, 65535));
            rs = (i % 2) == 1;
            e  = model(rs, ra, rb);
            run_op($sformatf("rand%0d", i), rs, ra, rb, e, 0, 1'b1);
        end

        // Abandon an operation with reset after eight iterations.
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 16'd1000;
        divisor   = 16'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_q", 32'(quotient), 32'd0);
        check("midrst_r", 32'(remainder), 32'd0);
        check("midrst_dbz", 32'(div_by_zero), 32'd0);
        $display("op midrst 1000 / 9 abandoned at iteration 8");
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("midrst_no_done", 32'(seen), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);

        run_op("post_rst_9_3", 1'b0, 16'd9, 16'd3, '{q: 16'd3, r: 16'd0, dbz: 1'b0, lat: 17}, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
